// File: rtl/svi_event_pkg.sv
// Shared types and default sizing for the event-capture block.
// The record layout {xyz, ts} is used both in the struct and in the flattened FIFO word.
package svi_event_pkg;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_TS_W  = 8;

    typedef struct packed {
        logic [2:0]              xyz;
        logic [DEFAULT_TS_W-1:0] ts;
    } svi_event_t;

endpackage

// File: rtl/svi_event_if.sv
// Source bundle observed by the capture block.
// The capture block only ever reads x, y and z.
interface I;

    logic x;
    logic y;
    logic z;

    modport mon (input x, input y, input z);

endinterface

// File: rtl/svi_event_fifo.sv
// Circular-buffer FIFO with synchronous reset.
// Push while full is accepted only if a pop happens on the same edge.
module svi_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    typedef logic [PTR_W-1:0] ptr_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             wr_en, rd_en;

    function automatic ptr_t next_ptr(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full_o || rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (rd_en) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/svi_event_capture.sv
// Timestamps every change of {x,y,z} and queues it for a ready/valid consumer.
// Records that arrive while the queue is full and not draining are counted, not stored.
module svi_event_capture
    import svi_event_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int TS_W  = DEFAULT_TS_W
) (
    input  logic                   clk,
    input  logic                   rst,
    I.mon                          u_I,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [2:0]             o_xyz,
    output logic [TS_W-1:0]        o_ts,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [7:0]             o_ovf_cnt
);

    localparam int REC_W = TS_W + 3;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [2:0]       prev_q, prev_d;
    logic [7:0]       ovf_q, ovf_d;
    logic [2:0]       cur_xyz;
    logic             push, pop, full, empty;
    logic [REC_W-1:0] wr_rec, rd_rec;

    assign cur_xyz = {u_I.x, u_I.y, u_I.z};
    assign pop     = !empty && i_ready;
    assign wr_rec  = {cur_xyz, ts_q};

    // Case inequality makes an X/Z input count as a change in simulation.
    always_comb begin
        ts_d   = ts_q + 1'b1;
        prev_d = cur_xyz;
        push   = (cur_xyz !== prev_q);
        ovf_d  = ovf_q;
        if (push && full && !pop && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q   <= '0;
            prev_q <= 3'b000;
            ovf_q  <= '0;
        end else begin
            ts_q   <= ts_d;
            prev_q <= prev_d;
            ovf_q  <= ovf_d;
        end
    end

    svi_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (wr_rec),
        .pop_i   (pop),
        .data_o  (rd_rec),
        .full_o  (full),
        .empty_o (empty),
        .count_o (o_count)
    );

    assign o_valid   = !empty;
    assign o_xyz     = rd_rec[REC_W-1 -: 3];
    assign o_ts      = rd_rec[TS_W-1:0];
    assign o_ovf_cnt = ovf_q;

endmodule

// File: tb/tb_svi_event_capture.sv
// Self-checking bench: a hand-derived vector table for the opening sequence,
// then a queue-based reference model for the overflow, wrap and reset corners.
module tb_svi_event_capture;
    import svi_event_pkg::*;

    localparam int DEPTH = 4;
    localparam int TS_W  = 8;

    logic            clk;
    logic            rst;
    logic            i_ready;
    logic            o_valid;
    logic [2:0]      o_xyz;
    logic [TS_W-1:0] o_ts;
    logic [2:0]      o_count;
    logic [7:0]      o_ovf_cnt;

    I u_if ();

    svi_event_capture #(
        .DEPTH (DEPTH),
        .TS_W  (TS_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .u_I       (u_if),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_xyz     (o_xyz),
        .o_ts      (o_ts),
        .o_count   (o_count),
        .o_ovf_cnt (o_ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         edgesSinceReset = 0;
    svi_event_t sbQ[$];
    logic [7:0] mTs;
    logic [7:0] mOvf;
    logic [2:0] mPrev;
    logic [2:0] cur;

    typedef struct {
        logic [2:0] xyz;
        logic       rdy;
        logic       rs;
        logic       expValid;
        int         expCount;
        logic [2:0] expXyz;
        logic [7:0] expTs;
    } vec_t;

    vec_t vecs[8];

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, advances the reference model, and returns #1 after the edge.
    task automatic applyStimulus(input logic [2:0] xyz, input logic rdy, input logic rs);
        bit push, pop, full;
        u_if.x  = xyz[2];
        u_if.y  = xyz[1];
        u_if.z  = xyz[0];
        i_ready = rdy;
        rst     = rs;
        if (rs) begin
            sbQ.delete();
            mTs   = '0;
            mPrev = 3'b000;
            mOvf  = '0;
            edgesSinceReset = 0;
        end else begin
            push = (xyz != mPrev);
            pop  = (sbQ.size() > 0) && rdy;
            full = (sbQ.size() == DEPTH);
            if (pop) void'(sbQ.pop_front());
            if (push) begin
                if (!full || pop) sbQ.push_back('{xyz: xyz, ts: mTs});
                else if (mOvf != 8'hFF) mOvf = mOvf + 8'd1;
            end
            mPrev = xyz;
            mTs   = mTs + 8'd1;
            edgesSinceReset++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkEq({tag, ".valid"}, o_valid, sbQ.size() != 0);
        checkEq({tag, ".count"}, o_count, sbQ.size());
        checkEq({tag, ".ovf"}, o_ovf_cnt, mOvf);
        if (sbQ.size() != 0) begin
            checkEq({tag, ".xyz"}, o_xyz, sbQ[0].xyz);
            checkEq({tag, ".ts"}, o_ts, sbQ[0].ts);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{xyz: 3'b010, rdy: 1'b0, rs: 1'b1, expValid: 1'b0, expCount: 0, expXyz: 3'b000, expTs: 8'd0};
        vecs[1] = '{xyz: 3'b010, rdy: 1'b0, rs: 1'b0, expValid: 1'b1, expCount: 1, expXyz: 3'b010, expTs: 8'd0};
        vecs[2] = '{xyz: 3'b010, rdy: 1'b0, rs: 1'b0, expValid: 1'b1, expCount: 1, expXyz: 3'b010, expTs: 8'd0};
        vecs[3] = '{xyz: 3'b010, rdy: 1'b0, rs: 1'b0, expValid: 1'b1, expCount: 1, expXyz: 3'b010, expTs: 8'd0};
        vecs[4] = '{xyz: 3'b110, rdy: 1'b1, rs: 1'b0, expValid: 1'b1, expCount: 1, expXyz: 3'b110, expTs: 8'd3};
        vecs[5] = '{xyz: 3'b010, rdy: 1'b1, rs: 1'b0, expValid: 1'b1, expCount: 1, expXyz: 3'b010, expTs: 8'd4};
        vecs[6] = '{xyz: 3'b110, rdy: 1'b1, rs: 1'b0, expValid: 1'b1, expCount: 1, expXyz: 3'b110, expTs: 8'd5};
        vecs[7] = '{xyz: 3'b110, rdy: 1'b1, rs: 1'b0, expValid: 1'b0, expCount: 0, expXyz: 3'b000, expTs: 8'd0};

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].xyz, vecs[i].rdy, vecs[i].rs);
            checkEq($sformatf("vec%0d.valid", i), o_valid, vecs[i].expValid);
            checkEq($sformatf("vec%0d.count", i), o_count, vecs[i].expCount);
            if (vecs[i].expValid) begin
                checkEq($sformatf("vec%0d.xyz", i), o_xyz, vecs[i].expXyz);
                checkEq($sformatf("vec%0d.ts", i), o_ts, vecs[i].expTs);
            end
            checkOutput($sformatf("vec%0d", i));
        end

        // Overfill: DEPTH+3 changes with the consumer stalled.
        cur = 3'b110;
        for (int i = 0; i < DEPTH + 3; i++) begin
            cur = cur ^ 3'b001;
            applyStimulus(cur, 1'b0, 1'b0);
            checkOutput("fill");
        end
        checkEq("ovf.count", o_count, 4);
        checkEq("ovf.ovfcnt", o_ovf_cnt, 3);
        checkEq("ovf.headxyz", o_xyz, 3'b111);

        // Full queue, change and pop on the same edge.
        cur = cur ^ 3'b001;
        applyStimulus(cur, 1'b1, 1'b0);
        checkOutput("fullpp");
        checkEq("fullpp.count", o_count, 4);
        checkEq("fullpp.ovfcnt", o_ovf_cnt, 3);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) checkEq("fullpp.tailxyz", o_xyz, 3'b110);
            applyStimulus(cur, 1'b1, 1'b0);
            checkOutput("drain");
        end
        checkEq("drain.empty", o_count, 0);

        // Timestamp wrap after a long quiet stretch.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(cur, 1'b0, 1'b0);
        end
        checkOutput("quiet");
        begin
            int expTs;
            expTs = edgesSinceReset % 256;
            cur = cur ^ 3'b100;
            applyStimulus(cur, 1'b0, 1'b0);
            checkEq("wrap.ts", o_ts, expTs);
            checkEq("wrap.count", o_count, 1);
            checkOutput("wrap");
        end
        applyStimulus(cur, 1'b1, 1'b0);
        checkOutput("wrapdrain");

        // Saturation of the drop counter.
        for (int i = 0; i < 262; i++) begin
            cur = cur ^ 3'b010;
            applyStimulus(cur, 1'b0, 1'b0);
        end
        checkOutput("sat");
        checkEq("sat.ovfcnt", o_ovf_cnt, 255);
        checkEq("sat.count", o_count, 4);

        // Mid-operation reset with 3 records queued and 5 drops.
        applyStimulus(cur, 1'b0, 1'b1);
        checkOutput("rst1");
        for (int i = 0; i < DEPTH + 5; i++) begin
            cur = cur ^ 3'b001;
            applyStimulus(cur, 1'b0, 1'b0);
        end
        applyStimulus(cur, 1'b1, 1'b0);
        checkOutput("pre_rst");
        checkEq("pre_rst.count", o_count, 3);
        checkEq("pre_rst.ovfcnt", o_ovf_cnt, 5);
        applyStimulus(cur, 1'b0, 1'b1);
        checkEq("rst2.valid", o_valid, 0);
        checkEq("rst2.count", o_count, 0);
        checkEq("rst2.ovfcnt", o_ovf_cnt, 0);
        applyStimulus(cur, 1'b0, 1'b0);
        checkOutput("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/svi_event_capture.md
SVI_EVENT_CAPTURE -- requirements
Module: svi_event_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning event FIFO depth (power of 2, >=2).
REQ-002 SHALL have parameter TS_W, default 8, meaning timestamp width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port u_I  interface I  -  source bundle; x, y, z read only, never driven.
REQ-006 SHALL have port o_valid  output  1  FIFO head holds a record.
REQ-007 SHALL have port i_ready  input  1  consumer accepts head this cycle.
REQ-008 SHALL have port o_xyz  output  3  head record value {x,y,z}, x is MSB.
REQ-009 SHALL have port o_ts  output  TS_W  head record timestamp.
REQ-010 SHALL have port o_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 SHALL have port o_ovf_cnt  output  8  dropped-record count, saturating.

Function
REQ-012 SHALL keep free-running timestamp counter ts, +1 every cycle, wrapping 2^TS_W-1 -> 0.
REQ-013 SHALL keep register prev (3 bits) holding last sampled {x,y,z}, updated every cycle.
REQ-014 SHALL generate a push at a rising edge when current {x,y,z} != prev; record = {ts before increment, current {x,y,z}}.
REQ-015 SHALL make a pushed record visible on o_valid/o_xyz/o_ts the cycle after the edge (1-cycle latency); no combinational path u_I -> outputs.
REQ-016 SHALL pop the head at a rising edge when o_valid && i_ready; i_ready while !o_valid has no effect.
REQ-017 SHALL hold o_xyz/o_ts stable while o_valid && !i_ready.
REQ-018 SHALL present the head record as valid data only when o_valid=1; o_xyz and o_ts are don't-care otherwise.
REQ-019 SHALL, on push when full and no pop, drop the new record and increment o_ovf_cnt, saturating at 255.
REQ-020 SHALL, on simultaneous push and pop when full, accept the push (no drop, o_count stays DEPTH).
REQ-021 SHALL, on simultaneous push and pop when count=1, output the new record next cycle with o_count=1.
REQ-022 SHALL implement the FIFO as a circular buffer; read and write pointers wrap DEPTH-1 -> 0.
REQ-023 SHALL treat X/Z on x, y or z as non-matching in simulation only; synthesis behaviour is 2-state.

Reset
REQ-024 SHALL, while rst=1 at an edge, set ts=0, prev=3'b000, FIFO empty, o_ovf_cnt=0; no push occurs on that edge.
REQ-025 SHALL drive o_valid=0 and o_count=0 the cycle after reset; o_xyz and o_ts are don't-care.
REQ-026 SHALL, on reset mid-operation, discard all queued records; o_ovf_cnt also clears.

Structure
REQ-027 SHALL place typedef svi_event_t {logic [2:0] xyz; logic [TS_W-1:0] ts} and the default constants in package svi_event_pkg.
REQ-028 SHALL instantiate one sub-module svi_event_fifo (parameterised DEPTH and width, sync reset) for storage; change detection and counters stay in the top level.

Verification
REQ-029 SHALL cover: reset release with x=0,y=1,z=0 held and i_ready=0 -> one record {3'b010, ts=0} after the first edge, o_count=1, no further pushes.
REQ-030 SHALL cover: with i_ready=1, toggle x on 3 consecutive cycles -> 3 records, xyz 110,010,110, consecutive ts, each valid for 1 cycle.
REQ-031 SHALL cover: i_ready=0, DEPTH+3 changes -> o_count=4, o_ovf_cnt=3, head still the first record.
REQ-032 SHALL cover: full FIFO, change and i_ready=1 on the same cycle -> no drop, o_count=4, new record at tail.
REQ-033 SHALL cover: hold inputs constant across 256+ cycles, then one change -> record ts equals the wrapped counter value (ts mod 2^TS_W).
REQ-034 SHALL cover: assert rst with 3 records queued and o_ovf_cnt=5 -> next cycle o_valid=0, o_count=0, o_ovf_cnt=0.
